// File: rtl/bsg_manycore_host_timer_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bsg_manycore_host_timer_decoder_pkg
// Brief    : Shared types and constants for the host timer-print decoder.
// Revision : 1.0
// ============================================================================
package bsg_manycore_host_timer_decoder_pkg;

    // Also used by the timer-request stage that splits the counter into two words.
    localparam int TIMER_WIDTH = 64;

    typedef enum logic [0:0] {
        S_LOW  = 1'b0,
        S_HIGH = 1'b1
    } pair_state_e;

endpackage
`default_nettype wire

// File: rtl/bsg_manycore_host_timer_decoder_rec.sv
`default_nettype none
// ============================================================================
// Module   : bsg_manycore_host_timer_decoder_rec
// Brief    : One-entry timestamp record with previous-value delta tracking.
// Revision : 1.0
// ============================================================================
module bsg_manycore_host_timer_decoder_rec
    import bsg_manycore_host_timer_decoder_pkg::*;
#(
    parameter int x_cord_width_p = 6,
    parameter int y_cord_width_p = 5
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      load_i,
    input  logic [31:0]               lo_i,
    input  logic [31:0]               hi_i,
    input  logic [x_cord_width_p-1:0] x_cord_i,
    input  logic [y_cord_width_p-1:0] y_cord_i,
    input  logic                      yumi_i,
    output logic                      v_o,
    output logic [TIMER_WIDTH-1:0]    ts_o,
    output logic [TIMER_WIDTH-1:0]    delta_o,
    output logic                      first_o,
    output logic [x_cord_width_p-1:0] x_cord_o,
    output logic [y_cord_width_p-1:0] y_cord_o
);

    logic                      ts_v_q,  ts_v_d;
    logic [TIMER_WIDTH-1:0]    ts_q,    ts_d;
    logic [TIMER_WIDTH-1:0]    delta_q, delta_d;
    logic                      first_q, first_d;
    logic [x_cord_width_p-1:0] x_q,     x_d;
    logic [y_cord_width_p-1:0] y_q,     y_d;
    logic [TIMER_WIDTH-1:0]    prev_q,  prev_d;
    logic                      seen_q,  seen_d;
    logic [TIMER_WIDTH-1:0]    ts_new;

    assign ts_new = {hi_i, lo_i};

    always_comb begin
        ts_v_d  = ts_v_q & ~yumi_i;
        ts_d    = ts_q;
        delta_d = delta_q;
        first_d = first_q;
        x_d     = x_q;
        y_d     = y_q;
        prev_d  = prev_q;
        seen_d  = seen_q;
        if (load_i) begin
            ts_v_d  = 1'b1;
            ts_d    = ts_new;
            // Modular subtraction covers counter wrap; the first record has no predecessor.
            delta_d = seen_q ? (ts_new - prev_q) : '0;
            first_d = ~seen_q;
            x_d     = x_cord_i;
            y_d     = y_cord_i;
            prev_d  = ts_new;
            seen_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ts_v_q  <= 1'b0;
            ts_q    <= '0;
            delta_q <= '0;
            first_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            prev_q  <= '0;
            seen_q  <= 1'b0;
        end else begin
            ts_v_q  <= ts_v_d;
            ts_q    <= ts_d;
            delta_q <= delta_d;
            first_q <= first_d;
            x_q     <= x_d;
            y_q     <= y_d;
            prev_q  <= prev_d;
            seen_q  <= seen_d;
        end
    end

    assign v_o      = ts_v_q;
    assign ts_o     = ts_q;
    assign delta_o  = delta_q;
    assign first_o  = first_q;
    assign x_cord_o = x_q;
    assign y_cord_o = y_q;

endmodule
`default_nettype wire

// File: rtl/bsg_manycore_host_timer_decoder.sv
`default_nettype none
// ============================================================================
// Module   : bsg_manycore_host_timer_decoder
// Brief    : Reassembles low/high timer packets into 64-bit records; bypasses the rest.
// Revision : 1.0
// ============================================================================
module bsg_manycore_host_timer_decoder
    import bsg_manycore_host_timer_decoder_pkg::*;
#(
    parameter int                    x_cord_width_p = 6,
    parameter int                    y_cord_width_p = 5,
    parameter int                    addr_width_p   = 28,
    parameter int                    data_width_p   = 32,
    parameter logic [addr_width_p-1:0] timer_addr_p = 'h3AB5
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           v_i,
    output logic                           rdy_o,
    input  logic [data_width_p-1:0]        data_i,
    input  logic [(data_width_p>>3)-1:0]   mask_i,
    input  logic [addr_width_p-1:0]        addr_i,
    input  logic                           we_i,
    input  logic [x_cord_width_p-1:0]      src_x_cord_i,
    input  logic [y_cord_width_p-1:0]      src_y_cord_i,
    output logic                           v_o,
    input  logic                           ready_i,
    output logic [data_width_p-1:0]        data_o,
    output logic [(data_width_p>>3)-1:0]   mask_o,
    output logic [addr_width_p-1:0]        addr_o,
    output logic                           we_o,
    output logic [x_cord_width_p-1:0]      src_x_cord_o,
    output logic [y_cord_width_p-1:0]      src_y_cord_o,
    output logic                           ts_v_o,
    input  logic                           ts_yumi_i,
    output logic [TIMER_WIDTH-1:0]         ts_o,
    output logic [TIMER_WIDTH-1:0]         ts_delta_o,
    output logic                           ts_first_o,
    output logic [x_cord_width_p-1:0]      ts_x_cord_o,
    output logic [y_cord_width_p-1:0]      ts_y_cord_o,
    output logic                           pair_err_o
);

    localparam int MASK_W = data_width_p >> 3;

    pair_state_e               state_q,    state_d;
    logic [31:0]               lo_q,       lo_d;
    logic [x_cord_width_p-1:0] lo_x_q,     lo_x_d;
    logic [y_cord_width_p-1:0] lo_y_q,     lo_y_d;
    logic                      pair_err_q, pair_err_d;

    logic                      byp_v_q,    byp_v_d;
    logic [data_width_p-1:0]   byp_data_q, byp_data_d;
    logic [MASK_W-1:0]         byp_mask_q, byp_mask_d;
    logic [addr_width_p-1:0]   byp_addr_q, byp_addr_d;
    logic                      byp_we_q,   byp_we_d;
    logic [x_cord_width_p-1:0] byp_x_q,    byp_x_d;
    logic [y_cord_width_p-1:0] byp_y_q,    byp_y_d;

    logic accept, is_timer, coord_match, byp_load, rec_load, rec_v;

    // A pending record blocks everything: the next packet might be a timer word.
    assign rdy_o       = ~rec_v & (~byp_v_q | ready_i);
    assign accept      = v_i & rdy_o;
    assign is_timer    = (addr_i == timer_addr_p) & we_i & (&mask_i);
    assign coord_match = (src_x_cord_i == lo_x_q) & (src_y_cord_i == lo_y_q);
    assign byp_load    = accept & ~is_timer;
    assign rec_load    = accept & is_timer & (state_q == S_HIGH) & coord_match;

    always_comb begin
        state_d    = state_q;
        lo_d       = lo_q;
        lo_x_d     = lo_x_q;
        lo_y_d     = lo_y_q;
        pair_err_d = 1'b0;
        if (accept) begin
            case (state_q)
                S_LOW: begin
                    if (is_timer) begin
                        state_d = S_HIGH;
                        lo_d    = data_i[31:0];
                        lo_x_d  = src_x_cord_i;
                        lo_y_d  = src_y_cord_i;
                    end
                end
                default: begin
                    state_d    = S_LOW;
                    pair_err_d = ~(is_timer & coord_match);
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_LOW;
            lo_q       <= '0;
            lo_x_q     <= '0;
            lo_y_q     <= '0;
            pair_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lo_q       <= lo_d;
            lo_x_q     <= lo_x_d;
            lo_y_q     <= lo_y_d;
            pair_err_q <= pair_err_d;
        end
    end

    always_comb begin
        byp_v_d    = byp_load | (byp_v_q & ~ready_i);
        byp_data_d = byp_load ? data_i       : byp_data_q;
        byp_mask_d = byp_load ? mask_i       : byp_mask_q;
        byp_addr_d = byp_load ? addr_i       : byp_addr_q;
        byp_we_d   = byp_load ? we_i         : byp_we_q;
        byp_x_d    = byp_load ? src_x_cord_i : byp_x_q;
        byp_y_d    = byp_load ? src_y_cord_i : byp_y_q;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) byp_v_q <= 1'b0;
        else         byp_v_q <= byp_v_d;
    end

    // Payload is qualified by byp_v_q, so it needs no reset.
    always_ff @(posedge clk_i) begin
        byp_data_q <= byp_data_d;
        byp_mask_q <= byp_mask_d;
        byp_addr_q <= byp_addr_d;
        byp_we_q   <= byp_we_d;
        byp_x_q    <= byp_x_d;
        byp_y_q    <= byp_y_d;
    end

    bsg_manycore_host_timer_decoder_rec #(
        .x_cord_width_p (x_cord_width_p),
        .y_cord_width_p (y_cord_width_p)
    ) u_rec (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .load_i   (rec_load),
        .lo_i     (lo_q),
        .hi_i     (data_i[31:0]),
        .x_cord_i (lo_x_q),
        .y_cord_i (lo_y_q),
        .yumi_i   (ts_yumi_i),
        .v_o      (rec_v),
        .ts_o     (ts_o),
        .delta_o  (ts_delta_o),
        .first_o  (ts_first_o),
        .x_cord_o (ts_x_cord_o),
        .y_cord_o (ts_y_cord_o)
    );

    assign v_o          = byp_v_q;
    assign data_o       = byp_data_q;
    assign mask_o       = byp_mask_q;
    assign addr_o       = byp_addr_q;
    assign we_o         = byp_we_q;
    assign src_x_cord_o = byp_x_q;
    assign src_y_cord_o = byp_y_q;
    assign ts_v_o       = rec_v;
    assign pair_err_o   = pair_err_q;

endmodule
`default_nettype wire
